// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache responder: address split,
// frame layout and responder state encoding.
package cpu_types_pkg;

    localparam int SETS  = 16;
    localparam int IDX_W = 4;
    localparam int TAG_W = 32 - IDX_W - 2;

    // Fetch address viewed as tag / index / byte offset.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [1:0]       bytoff;
    } icachef_t;

    // One direct-mapped frame holding a single word.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    // Clears the byte offset so memory only ever sees word addresses.
    function automatic logic [31:0] word_align(input icachef_t a);
        return {a.tag, a.idx, 2'b00};
    endfunction

endpackage

// File: rtl/icache_frame_array.sv
// Frame storage for the instruction cache: SETS frames, one combinational
// read port and one write port that updates on the rising clock edge.
// All frames clear asynchronously when nRST is low.
module icache_frame_array
    import cpu_types_pkg::*;
(
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [IDX_W-1:0]     ridx,
    output icache_frame_t        rframe,
    input  logic                 wen,
    input  logic [IDX_W-1:0]     widx,
    input  icache_frame_t        wframe
);

    icache_frame_t frames_q [SETS];

    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_frame
            // Each frame loads the fill word when it is the write target.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    frames_q[gi] <= '0;
                end else if (wen && (widx == IDX_W'(gi))) begin
                    frames_q[gi] <= wframe;
                end
            end
        end
    endgenerate

    // Zero-latency lookup so a hit is reported in the request cycle.
    assign rframe = frames_q[ridx];

endmodule

// File: rtl/icache_responder.sv
// Instruction cache responder: direct-mapped, one word per frame, read-only.
// Hits are answered combinationally in IDLE; a miss latches the word
// address, holds iREN in FETCH until memory drops iwait, fills the frame
// and returns to IDLE to re-check the current fetch address.
// Optional build macro ICACHE_PERF_EN adds hit/miss performance counters;
// without it hit_count and miss_count are tied to zero.
module icache_responder
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    icache_state_t state_q, state_d;
    logic [31:0]   miss_q, miss_d;
    logic          iren_q, iren_d;

    icachef_t      req_f;
    icachef_t      miss_f;
    icache_frame_t rd_frame;
    icache_frame_t wr_frame;
    logic          wr_en;
    logic          hit;
    logic          miss_start;
    logic          bytoff_unused;

    assign req_f  = icachef_t'(imemaddr);
    assign miss_f = icachef_t'(miss_q);

    // The byte offset plays no part in lookup or fill.
    assign bytoff_unused = ^req_f.bytoff;

    icache_frame_array u_frames (
        .CLK    (CLK),
        .nRST   (nRST),
        .ridx   (req_f.idx),
        .rframe (rd_frame),
        .wen    (wr_en),
        .widx   (miss_f.idx),
        .wframe (wr_frame)
    );

    // Hit detection and fill-frame assembly.
    always_comb begin
        hit        = (state_q == IDLE) && imemREN && rd_frame.valid &&
                     (rd_frame.tag == req_f.tag);
        miss_start = (state_q == IDLE) && imemREN && !hit;
        wr_en      = (state_q == FETCH) && !iwait;
        wr_frame   = '{valid: 1'b1, tag: miss_f.tag, data: iload};
    end

    assign ihit     = hit;
    assign imemload = hit ? rd_frame.data : 32'h0;
    assign iREN     = iren_q;
    assign iaddr    = miss_q;

    // Next-state logic: IDLE latches a miss, FETCH waits out memory latency.
    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        iren_d  = iren_q;
        unique case (state_q)
            IDLE: begin
                if (miss_start) begin
                    state_d = FETCH;
                    miss_d  = word_align(req_f);
                    iren_d  = 1'b1;
                end
            end
            FETCH: begin
                if (!iwait) begin
                    state_d = IDLE;
                    iren_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                iren_d  = 1'b0;
            end
        endcase
    end

    // Responder state, miss address and registered memory request.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            miss_q  <= 32'h0;
            iren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            iren_q  <= iren_d;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        hit_cnt_d  = hit_cnt_q + {31'b0, hit};
        miss_cnt_d = miss_cnt_q + {31'b0, miss_start};
    end

    // Performance counters clear only on reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = 32'h0;
    assign miss_count = 32'h0;
`endif

endmodule
